ldpc_llr_loader: RTL and testbench

Input stage directly upstream of `ldpc_core`. Accepts quantized channel LLRs as a valid/ready stream of P samples per beat, saturates them to the decoder word width, and packs them into one of two frame banks. It then sequences the core: a reset pulse, then enable until `term`. Double buffering lets frame N+1 load while frame N decodes; the core's `l` bus stays stable for the whole decode.

---
 rtl/ldpc_pkg.sv | 33 +++
 rtl/llr_sat.sv | 15 +
 rtl/ldpc_llr_loader.sv | 163 ++++++++++++++++
 tb/tb_ldpc_llr_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared helpers for the LDPC input path: width math, LLR saturation and
// the decode-sequencer state encoding.
package ldpc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2
  } dec_state_t;

  function automatic int log2(input int n);
    return $clog2(n);
  endfunction

  // in holds an in_w-bit two's complement code in its low bits; the result is
  // clamped symmetrically so the most negative data_w code never appears.
  function automatic logic signed [31:0] sat_llr(input logic [31:0] in,
                                                 input int in_w,
                                                 input int data_w);
    logic signed [31:0] v;
    logic signed [31:0] lim;
    v   = $signed(in << (32 - in_w)) >>> (32 - in_w);
    lim = (32'sd1 <<< (data_w - 1)) - 32'sd1;
    if (v > lim) begin
      return lim;
    end
    if (v < -lim) begin
      return -lim;
    end
    return v;
  endfunction

endpackage

// File: rtl/llr_sat.sv
// Combinational clamp of one channel LLR to the decoder word width.
module llr_sat #(
  parameter int in_w   = 8,
  parameter int data_w = 5
) (
  input  logic [in_w-1:0]   in_llr,
  output logic [data_w-1:0] out_llr
);
  import ldpc_pkg::*;

  always_comb begin
    out_llr = data_w'(sat_llr(32'(in_llr), in_w, data_w));
  end

endmodule

// File: rtl/ldpc_llr_loader.sv
// Double-buffered LLR frame loader feeding ldpc_core: saturates and packs the
// input stream into two banks and sequences core reset/enable per frame.
module ldpc_llr_loader #(
  parameter int data_w = 5,
  parameter int in_w   = 8,
  parameter int R      = 24,
  parameter int D      = 96,
  parameter int P      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [P*in_w-1:0]       s_data,
  input  logic                    s_last,
  output logic [R*D*data_w-1:0]   l,
  output logic                    core_rst,
  output logic                    core_en,
  input  logic                    core_term,
  input  logic                    core_err,
  output logic                    done,
  output logic                    dec_err,
  output logic                    frame_err,
  output logic                    busy
);
  import ldpc_pkg::*;

  localparam int BEATS  = R * D / P;
  localparam int cnt_w  = log2(BEATS);
  localparam int BANK_W = R * D * data_w;
  localparam int BEAT_W = P * data_w;
  localparam logic [cnt_w-1:0] LAST_BEAT = cnt_w'(BEATS - 1);

  logic [1:0][BANK_W-1:0] bank_q, bank_d;
  logic [1:0]             full_q, full_d;
  logic                   wr_sel_q, wr_sel_d;
  logic                   rd_sel_q, rd_sel_d;
  logic [cnt_w-1:0]       beat_cnt_q, beat_cnt_d;
  dec_state_t             state_q, state_d;
  logic                   done_q, done_d;
  logic                   dec_err_q, dec_err_d;
  logic                   frame_err_q, frame_err_d;

  logic [BEAT_W-1:0]      sat_beat;
  logic                   beat_acc;
  logic                   fill_done;
  logic                   dec_release;

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : gen_sat
      llr_sat #(
        .in_w   (in_w),
        .data_w (data_w)
      ) u_sat (
        .in_llr  (s_data[gi*in_w +: in_w]),
        .out_llr (sat_beat[gi*data_w +: data_w])
      );
    end
  endgenerate

  // Ready is forced low during reset so no beat can slip in as it releases.
  assign s_ready  = rst_n & ~full_q[wr_sel_q];
  assign beat_acc = s_valid & s_ready;

  always_comb begin
    bank_d      = bank_q;
    wr_sel_d    = wr_sel_q;
    beat_cnt_d  = beat_cnt_q;
    frame_err_d = 1'b0;
    fill_done   = 1'b0;
    if (beat_acc) begin
      bank_d[wr_sel_q][int'(beat_cnt_q)*BEAT_W +: BEAT_W] = sat_beat;
      if (s_last && (beat_cnt_q == LAST_BEAT)) begin
        fill_done  = 1'b1;
        wr_sel_d   = ~wr_sel_q;
        beat_cnt_d = '0;
      end else if (s_last || (beat_cnt_q == LAST_BEAT)) begin
        // Malformed frame: bank stays empty and is simply refilled.
        frame_err_d = 1'b1;
        beat_cnt_d  = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_sel_d    = rd_sel_q;
    done_d      = 1'b0;
    dec_err_d   = dec_err_q;
    dec_release = 1'b0;
    core_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_sel_q]) begin
          state_d = CLR;
        end
      end
      CLR: begin
        state_d = RUN;
      end
      RUN: begin
        // Enable drops in the term cycle so the core's results are not rewritten.
        core_en = ~core_term;
        if (core_term) begin
          done_d      = 1'b1;
          dec_err_d   = core_err;
          dec_release = 1'b1;
          rd_sel_d    = ~rd_sel_q;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Fill and release always hit different banks, so both may land together.
  always_comb begin
    full_d = full_q;
    if (fill_done) begin
      full_d[wr_sel_q] = 1'b1;
    end
    if (dec_release) begin
      full_d[rd_sel_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q      <= '0;
      full_q      <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      beat_cnt_q  <= '0;
      state_q     <= IDLE;
      done_q      <= 1'b0;
      dec_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      beat_cnt_q  <= beat_cnt_d;
      state_q     <= state_d;
      done_q      <= done_d;
      dec_err_q   <= dec_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign l         = bank_q[rd_sel_q];
  assign core_rst  = ~rst_n | (state_q == CLR);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dec_err   = dec_err_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ldpc_llr_loader.sv
// Scoreboard bench for ldpc_llr_loader: random frames against an integer
// saturation model, with a simple core model answering enable with term.
module tb_ldpc_llr_loader;

  localparam int data_w = 5;
  localparam int in_w   = 8;
  localparam int R      = 24;
  localparam int D      = 96;
  localparam int P      = 8;
  localparam int BEATS  = R * D / P;
  localparam int N      = R * D;
  localparam int TOT    = N * data_w;

  typedef struct {
    int delay;
    int err;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [P*in_w-1:0] s_data = '0;
  logic s_last = 1'b0;
  logic [TOT-1:0] l;
  logic core_rst, core_en;
  logic core_term = 1'b0;
  logic core_err = 1'b0;
  logic done, dec_err, frame_err, busy;

  int checks = 0;
  int errors = 0;

  logic [TOT-1:0] exp_frames[$];
  cfg_t           cfg_q[$];
  logic           exp_err_q[$];
  logic           fe_q[$];

  always #5 clk = ~clk;

  ldpc_llr_loader #(
    .data_w (data_w),
    .in_w   (in_w),
    .R      (R),
    .D      (D),
    .P      (P)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .l         (l),
    .core_rst  (core_rst),
    .core_en   (core_en),
    .core_term (core_term),
    .core_err  (core_err),
    .done      (done),
    .dec_err   (dec_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not met", name);
  endtask

  task automatic chk_l(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] req);
    int idx;
    logic signed [data_w-1:0] a;
    logic signed [data_w-1:0] r;
    checks++;
    if (act !== req) begin
      idx = 0;
      for (int i = N - 1; i >= 0; i--) begin
        if (act[i*data_w +: data_w] !== req[i*data_w +: data_w]) idx = i;
      end
      a = act[idx*data_w +: data_w];
      r = req[idx*data_w +: data_w];
      errors++;
      $display("FAIL %s: llr[%0d] got %0d expected %0d", name, idx, a, r);
    end
  endtask

  // Reference saturation on plain integers.
  function automatic int ref_sat(input int v);
    int lim;
    lim = 2 ** (data_w - 1) - 1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic send_beat(input logic [P*in_w-1:0] d, input logic last);
    int w;
    w = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) fail_msg("s_ready_timeout");
    @(negedge clk);
  endtask

  // Returns at the negedge just after the final beat was accepted.
  task automatic send_frame(input int nbeats, input int last_at, input bit directed,
                            input int delay, input int err, output logic [TOT-1:0] expv);
    logic [P*in_w-1:0] beat_data [BEATS];
    int dir_vals[6];
    int v, idx;
    bit good;
    cfg_t c;
    dir_vals = '{100, -100, -16, 3, -3, 0};
    expv = '0;
    good = (nbeats == BEATS) && (last_at == BEATS - 1);
    for (int b = 0; b < BEATS; b++) begin
      for (int p = 0; p < P; p++) begin
        idx = b * P + p;
        if (directed && idx < 6) v = dir_vals[idx];
        else v = int'($urandom_range(0, 2 ** in_w - 1)) - 2 ** (in_w - 1);
        beat_data[b][p*in_w +: in_w] = in_w'(v);
        expv[idx*data_w +: data_w] = data_w'(ref_sat(v));
      end
    end
    if (good) begin
      c.delay = delay;
      c.err   = err;
      exp_frames.push_back(expv);
      cfg_q.push_back(c);
    end else if (last_at >= 0 || nbeats == BEATS) begin
      fe_q.push_back(1'b1);
    end
    for (int b = 0; b < nbeats; b++) begin
      send_beat(beat_data[b], (b == last_at));
    end
  endtask

  task automatic wait_quiet();
    int w;
    w = 0;
    while ((busy || done || exp_frames.size() != 0 || exp_err_q.size() != 0 ||
            fe_q.size() != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) fail_msg("quiet_timeout");
    repeat (2) @(negedge clk);
  endtask

  // Monitor plus core model: answers each decode with term after a set delay.
  initial begin : monitor
    int rcnt, target, errv;
    logic in_run, prev_term, held_err;
    logic [TOT-1:0] cur;
    cfg_t c;
    in_run = 1'b0; prev_term = 1'b0; held_err = 1'b0; cur = '0;
    rcnt = 0; target = 5;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_run = 1'b0; prev_term = 1'b0; held_err = 1'b0;
        core_term = 1'b0; core_err = 1'b0;
      end else begin
        if (done || prev_term) begin
          chk("done_one_cycle_after_term", longint'(done), longint'(prev_term));
          if (done) begin
            if (exp_err_q.size() == 0) fail_msg("unexpected_done");
            else begin
              held_err = exp_err_q.pop_front();
              chk("dec_err_at_done", longint'(dec_err), longint'(held_err));
            end
          end
        end
        prev_term = 1'b0;
        core_term = 1'b0;
        core_err  = 1'b0;
        if (frame_err) begin
          chk("frame_err_expected", longint'(fe_q.size() > 0), 1);
          if (fe_q.size() > 0) void'(fe_q.pop_front());
        end
        if (core_rst) begin
          if (exp_frames.size() == 0) fail_msg("unexpected_clr");
          else begin
            cur = exp_frames.pop_front();
            chk_l("l_at_clr", l, cur);
          end
          chk("dec_err_held", longint'(dec_err), longint'(held_err));
          if (cfg_q.size() > 0) c = cfg_q.pop_front();
          else begin c.delay = 5; c.err = 0; end
          target = c.delay;
          errv   = (c.err < 0) ? int'($urandom_range(0, 1)) : c.err;
          rcnt   = 0;
          in_run = 1'b1;
        end else if (in_run) begin
          rcnt++;
          if (rcnt == 1) begin
            chk("core_en_after_clr", longint'(core_en), 1);
            chk("core_rst_one_cycle", longint'(core_rst), 0);
          end
          if (rcnt == target) begin
            chk_l("l_stable_in_run", l, cur);
            chk("core_en_before_term", longint'(core_en), 1);
            core_err  = errv[0];
            core_term = 1'b1;
            #1;
            chk("core_en_drops_on_term", longint'(core_en), 0);
            exp_err_q.push_back(errv[0]);
            prev_term = 1'b1;
            in_run    = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [TOT-1:0] ea, eb, ec;
    logic signed [data_w-1:0] sv;
    int exp_dir[6];
    int any_bad;
    exp_dir = '{15, -15, -15, 3, -3, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_s_ready", longint'(s_ready), 0);
    chk("rst_core_rst", longint'(core_rst), 1);
    chk("rst_core_en", longint'(core_en), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_dec_err", longint'(dec_err), 0);
    chk("rst_frame_err", longint'(frame_err), 0);
    chk("rst_busy", longint'(busy), 0);
    chk_l("rst_l", l, '0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_s_ready", longint'(s_ready), 1);
    chk("post_rst_core_rst", longint'(core_rst), 0);
    @(negedge clk);

    // Saturation frame and CLR/RUN timing
    send_frame(BEATS, BEATS - 1, 1'b1, 5, 1, ea);
    s_valid = 1'b0;
    chk("t_idle_core_rst", longint'(core_rst), 0);
    chk("t_idle_busy", longint'(busy), 0);
    @(negedge clk);
    chk("t1_core_rst", longint'(core_rst), 1);
    chk("t1_core_en", longint'(core_en), 0);
    @(negedge clk);
    chk("t2_core_en", longint'(core_en), 1);
    chk("t2_core_rst", longint'(core_rst), 0);
    for (int i = 0; i < 6; i++) begin
      sv = l[i*data_w +: data_w];
      chk($sformatf("sat_slice%0d", i), longint'(sv), longint'(exp_dir[i]));
    end
    wait_quiet();
    chk("dec_err_held_after_done", longint'(dec_err), 1);

    // Random frames, decoder and loader overlapping
    for (int f = 0; f < 3; f++) begin
      send_frame(BEATS, BEATS - 1, 1'b0, int'($urandom_range(1, 12)), -1, ea);
      s_valid = 1'b0;
      repeat (int'($urandom_range(0, 4))) @(negedge clk);
    end
    wait_quiet();

    // Three back-to-back frames, first decode long enough to stall the third
    send_frame(BEATS, BEATS - 1, 1'b0, 400, -1, ea);
    send_frame(BEATS, BEATS - 1, 1'b0, 5, -1, eb);
    chk("busy_during_frame2_load", longint'(busy), 1);
    chk("s_ready_frame3_start", longint'(s_ready), 0);
    any_bad = 0;
    while (!s_ready && any_bad < 2000) begin
      @(negedge clk);
      any_bad++;
    end
    if (!s_ready) fail_msg("frame3_ready_timeout");
    chk("done_when_ready_returns", longint'(done), 1);
    chk_l("l_switch_at_done", l, eb);
    send_frame(BEATS, BEATS - 1, 1'b0, 5, -1, ec);
    s_valid = 1'b0;
    wait_quiet();

    // Early s_last, then a good frame
    send_frame(11, 10, 1'b0, 0, 0, ea);
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("early_last_no_decode_busy", longint'(busy), 0);
    chk("early_last_seen", longint'(fe_q.size()), 0);
    send_frame(BEATS, BEATS - 1, 1'b0, 3, -1, ea);
    s_valid = 1'b0;
    wait_quiet();

    // Missing s_last on the final beat, then a good frame
    send_frame(BEATS, -1, 1'b0, 0, 0, ea);
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_last_s_ready", longint'(s_ready), 1);
    chk("no_last_busy", longint'(busy), 0);
    chk("no_last_seen", longint'(fe_q.size()), 0);
    send_frame(BEATS, BEATS - 1, 1'b0, 7, -1, ea);
    s_valid = 1'b0;
    wait_quiet();

    // Reset mid-RUN with a partial frame loading
    send_frame(BEATS, BEATS - 1, 1'b0, 1000, -1, ea);
    send_frame(50, -1, 1'b0, 0, 0, eb);
    chk("pre_reset_core_en", longint'(core_en), 1);
    rst_n = 1'b0;
    s_valid = 1'b0;
    exp_frames.delete();
    cfg_q.delete();
    exp_err_q.delete();
    fe_q.delete();
    #1;
    chk("mid_rst_core_rst", longint'(core_rst), 1);
    chk("mid_rst_core_en", longint'(core_en), 0);
    chk("mid_rst_s_ready", longint'(s_ready), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk_l("mid_rst_l", l, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready", longint'(s_ready), 1);
    chk("rel_busy", longint'(busy), 0);
    any_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || core_rst || busy) any_bad++;
    end
    chk("no_stale_activity", longint'(any_bad), 0);
    send_frame(BEATS, BEATS - 1, 1'b0, 4, -1, ea);
    s_valid = 1'b0;
    wait_quiet();

    chk("end_frames_drained", longint'(exp_frames.size()), 0);
    chk("end_dones_drained", longint'(exp_err_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
